// File: rtl/multi_sync_pkg.sv
// Shared limits and helpers for the multi-channel synchronizer/debouncer.
//   MIN_STAGES/MAX_STAGES : legal synchronizer depth
//   MIN_FILTER/MAX_FILTER : legal debounce length in cycles
//   MAX_WIDTH             : legal channel count
//   cnt_width()           : bits needed for a counter that reaches FILTER
package multi_sync_pkg;

    localparam int unsigned MIN_STAGES = 2;
    localparam int unsigned MAX_STAGES = 4;
    localparam int unsigned MIN_FILTER = 1;
    localparam int unsigned MAX_FILTER = 255;
    localparam int unsigned MIN_WIDTH  = 1;
    localparam int unsigned MAX_WIDTH  = 32;

    // Counter width able to hold the value FILTER.
    function automatic int unsigned cnt_width(input int unsigned filter);
        return $clog2(filter + 1);
    endfunction

endpackage

// File: rtl/sync_chan.sv
// Single channel: synchronizer chain, debounce counter, filtered level,
// edge pulses and sticky event flags.
// Ports:
//   clk, n_rst   : clock, async active-low reset
//   async_in     : asynchronous level input
//   evt_ack      : clears evt_pending / evt_overrun
//   sync_out     : last synchronizer stage
//   filt_out     : debounced level
//   rise, fall   : one-cycle pulses coincident with the first cycle of a new filt_out
//   evt_pending  : sticky, an edge occurred since the last ack
//   evt_overrun  : sticky, an edge occurred while evt_pending was already set
module sync_chan
    import multi_sync_pkg::*;
#(
    parameter int unsigned STAGES  = 2,
    parameter int unsigned FILTER  = 4,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic n_rst,
    input  logic async_in,
    input  logic evt_ack,
    output logic sync_out,
    output logic filt_out,
    output logic rise,
    output logic fall,
    output logic evt_pending,
    output logic evt_overrun
);

    localparam int unsigned CW = cnt_width(FILTER);

    if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("sync_chan: STAGES out of range");
    end
    if (FILTER < MIN_FILTER || FILTER > MAX_FILTER) begin : g_bad_filter
        $error("sync_chan: FILTER out of range");
    end

    logic [STAGES-1:0] chain;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt_c;
    logic              load_c;
    logic              evt_c;

    // Synchronizer shift chain; bit 0 samples the asynchronous input.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain[STAGES-1];

    // Debounce: count consecutive mismatching cycles, load on the FILTER-th.
    always_comb begin
        load_c    = 1'b0;
        cnt_nxt_c = '0;
        if (sync_out != filt_out) begin
            if (cnt == CW'(FILTER - 1)) begin
                load_c = 1'b1;
            end else begin
                cnt_nxt_c = cnt + CW'(1);
            end
        end
    end

    // Filtered level plus edge pulses registered on the same edge it changes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt      <= '0;
            filt_out <= RST_VAL;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            cnt  <= cnt_nxt_c;
            rise <= load_c & sync_out;
            fall <= load_c & ~sync_out;
            if (load_c) begin
                filt_out <= sync_out;
            end
        end
    end

    // Flags react to the visible pulse, so an ack during the pulse cycle
    // loses to the edge and the pending bit stays set.
    assign evt_c = rise | fall;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            evt_pending <= 1'b0;
            evt_overrun <= 1'b0;
        end else begin
            if (evt_c) begin
                evt_pending <= 1'b1;
                if (evt_pending) begin
                    evt_overrun <= 1'b1;
                end
            end else if (evt_ack && evt_pending) begin
                evt_pending <= 1'b0;
                evt_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_sync_debounce.sv
// WIDTH independent channels of synchronizer + debouncer + edge/event flags.
// Ports:
//   clk, n_rst   : clock, async active-low reset
//   async_in     : asynchronous level inputs
//   evt_ack      : per-channel clear of evt_pending / evt_overrun
//   sync_out     : raw synchronized levels
//   filt_out     : debounced levels
//   rise, fall   : one-cycle edge pulses of filt_out
//   evt_pending  : sticky edge-seen flags
//   evt_overrun  : sticky edge-while-pending flags
module multi_sync_debounce
    import multi_sync_pkg::*;
#(
    parameter int unsigned     WIDTH   = 4,
    parameter int unsigned     STAGES  = 2,
    parameter int unsigned     FILTER  = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] async_in,
    input  logic [WIDTH-1:0] evt_ack,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] evt_pending,
    output logic [WIDTH-1:0] evt_overrun
);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("multi_sync_debounce: WIDTH out of range");
    end

    // One fully independent channel per bit.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_chan
        sync_chan #(
            .STAGES  (STAGES),
            .FILTER  (FILTER),
            .RST_VAL (RST_VAL[i])
        ) u_chan (
            .clk         (clk),
            .n_rst       (n_rst),
            .async_in    (async_in[i]),
            .evt_ack     (evt_ack[i]),
            .sync_out    (sync_out[i]),
            .filt_out    (filt_out[i]),
            .rise        (rise[i]),
            .fall        (fall[i]),
            .evt_pending (evt_pending[i]),
            .evt_overrun (evt_overrun[i])
        );
    end

endmodule

// File: tb/tb_multi_sync_debounce.sv
// Directed bench: default instance (STAGES=2, FILTER=4, RST_VAL=0) and a
// STAGES=3, RST_VAL=4'b1010 instance sharing clock and reset.
module tb_multi_sync_debounce;

    logic       clk;
    logic       n_rst;
    logic [3:0] async_in, evt_ack;
    logic [3:0] sync_out, filt_out, rise, fall, evt_pending, evt_overrun;
    logic [3:0] a3, ack3;
    logic [3:0] s3, f3, r3, fl3, p3, o3;

    int errors;
    int checks;

    multi_sync_debounce #(
        .WIDTH(4), .STAGES(2), .FILTER(4), .RST_VAL(4'b0000)
    ) dut (
        .clk(clk), .n_rst(n_rst), .async_in(async_in), .evt_ack(evt_ack),
        .sync_out(sync_out), .filt_out(filt_out), .rise(rise), .fall(fall),
        .evt_pending(evt_pending), .evt_overrun(evt_overrun)
    );

    multi_sync_debounce #(
        .WIDTH(4), .STAGES(3), .FILTER(4), .RST_VAL(4'b1010)
    ) dut3 (
        .clk(clk), .n_rst(n_rst), .async_in(a3), .evt_ack(ack3),
        .sync_out(s3), .filt_out(f3), .rise(r3), .fall(fl3),
        .evt_pending(p3), .evt_overrun(o3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_all();
        evt_ack = 4'hF;
        tick(1);
        evt_ack = 4'h0;
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if ({sync_out, filt_out, rise, fall, evt_pending, evt_overrun} !== 24'h0)
            begin errors++; $display("FAIL reset_outputs: got %h expected 000000",
                {sync_out, filt_out, rise, fall, evt_pending, evt_overrun}); end
        checks++;
        if (s3 !== 4'b1010 || f3 !== 4'b1010)
            begin errors++; $display("FAIL reset_rstval: got sync=%b filt=%b expected 1010", s3, f3); end
        n_rst = 1'b1;
        tick(1);
        checks++;
        if (sync_out !== 4'h0)
            begin errors++; $display("FAIL sync_early: got %h expected 0", sync_out); end
        tick(1);
        checks++;
        if (sync_out !== 4'hF)
            begin errors++; $display("FAIL sync_latency: got %h expected f", sync_out); end
        tick(3);
        checks++;
        if (filt_out !== 4'h0 || rise !== 4'h0)
            begin errors++; $display("FAIL filt_early: got filt=%h rise=%h expected 0 0", filt_out, rise); end
        tick(1);
        checks++;
        if (filt_out !== 4'hF || rise !== 4'hF || fall !== 4'h0)
            begin errors++; $display("FAIL filt_rise: got filt=%h rise=%h fall=%h expected f f 0", filt_out, rise, fall); end
        tick(1);
        checks++;
        if (rise !== 4'h0 || evt_pending !== 4'hF || evt_overrun !== 4'h0)
            begin errors++; $display("FAIL rise_flags: got rise=%h pend=%h ovr=%h expected 0 f 0", rise, evt_pending, evt_overrun); end
    endtask

    task automatic test_overrun();
        async_in = 4'b1011;
        tick(5);
        checks++;
        if (filt_out !== 4'hF || fall !== 4'h0)
            begin errors++; $display("FAIL fall_early: got filt=%h fall=%h expected f 0", filt_out, fall); end
        tick(1);
        checks++;
        if (filt_out !== 4'b1011 || fall !== 4'b0100 || rise !== 4'h0)
            begin errors++; $display("FAIL fall_pulse: got filt=%b fall=%b rise=%b expected 1011 0100 0000", filt_out, fall, rise); end
        tick(1);
        checks++;
        if (fall !== 4'h0 || evt_pending !== 4'hF || evt_overrun !== 4'b0100)
            begin errors++; $display("FAIL overrun_set: got fall=%b pend=%b ovr=%b expected 0000 1111 0100", fall, evt_pending, evt_overrun); end
        evt_ack = 4'b0100;
        tick(1);
        evt_ack = 4'h0;
        checks++;
        if (evt_pending !== 4'b1011 || evt_overrun !== 4'h0)
            begin errors++; $display("FAIL ack_one: got pend=%b ovr=%b expected 1011 0000", evt_pending, evt_overrun); end
    endtask

    task automatic test_ack_idle();
        ack_all();
        checks++;
        if (evt_pending !== 4'h0)
            begin errors++; $display("FAIL ack_all: got pend=%b expected 0000", evt_pending); end
        ack_all();
        checks++;
        if (evt_pending !== 4'h0 || evt_overrun !== 4'h0 || filt_out !== 4'b1011)
            begin errors++; $display("FAIL ack_idle: got pend=%b ovr=%b filt=%b expected 0000 0000 1011", evt_pending, evt_overrun, filt_out); end
    endtask

    task automatic test_glitch();
        int hi;
        int bad;
        async_in = 4'b1001;
        tick(6);
        checks++;
        if (filt_out !== 4'b1001 || fall !== 4'b0010)
            begin errors++; $display("FAIL ch1_fall: got filt=%b fall=%b expected 1001 0010", filt_out, fall); end
        tick(1);
        ack_all();
        hi = 0;
        bad = 0;
        async_in[1] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (i == 3) async_in[1] = 1'b0;
            if (sync_out[1]) hi++;
            if (rise[1] || filt_out[1]) bad++;
        end
        checks++;
        if (hi != 3)
            begin errors++; $display("FAIL glitch_sync: got %0d high cycles expected 3", hi); end
        checks++;
        if (bad != 0)
            begin errors++; $display("FAIL glitch_filtered: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_boundary();
        async_in[1] = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick(1);
            if (i == 4) async_in[1] = 1'b0;
            if (i == 5) begin
                checks++;
                if (filt_out !== 4'b1001 || rise !== 4'h0)
                    begin errors++; $display("FAIL bnd_early: got filt=%b rise=%b expected 1001 0000", filt_out, rise); end
            end
            if (i == 6) begin
                checks++;
                if (filt_out !== 4'b1011 || rise !== 4'b0010)
                    begin errors++; $display("FAIL bnd_rise: got filt=%b rise=%b expected 1011 0010", filt_out, rise); end
            end
            if (i == 7) begin
                checks++;
                if (rise !== 4'h0 || evt_pending !== 4'b0010 || evt_overrun !== 4'h0)
                    begin errors++; $display("FAIL bnd_pulse: got rise=%b pend=%b ovr=%b expected 0000 0010 0000", rise, evt_pending, evt_overrun); end
            end
            if (i == 10) begin
                checks++;
                if (filt_out !== 4'b1001 || fall !== 4'b0010 || rise !== 4'h0)
                    begin errors++; $display("FAIL bnd_fall: got filt=%b fall=%b rise=%b expected 1001 0010 0000", filt_out, fall, rise); end
            end
            if (i == 11) begin
                checks++;
                if (evt_pending !== 4'b0010 || evt_overrun !== 4'b0010)
                    begin errors++; $display("FAIL bnd_overrun: got pend=%b ovr=%b expected 0010 0010", evt_pending, evt_overrun); end
            end
        end
        ack_all();
        checks++;
        if (evt_pending !== 4'h0 || evt_overrun !== 4'h0)
            begin errors++; $display("FAIL bnd_ack: got pend=%b ovr=%b expected 0000 0000", evt_pending, evt_overrun); end
    endtask

    task automatic test_ack_same_cycle();
        async_in[0] = 1'b0;
        tick(6);
        checks++;
        if (fall !== 4'b0001 || filt_out !== 4'b1000)
            begin errors++; $display("FAIL ch0_fall: got fall=%b filt=%b expected 0001 1000", fall, filt_out); end
        tick(1);
        ack_all();
        async_in[0] = 1'b1;
        tick(6);
        checks++;
        if (rise !== 4'b0001 || evt_pending !== 4'h0)
            begin errors++; $display("FAIL ch0_rise: got rise=%b pend=%b expected 0001 0000", rise, evt_pending); end
        evt_ack = 4'b0001;
        tick(1);
        evt_ack = 4'h0;
        checks++;
        if (evt_pending !== 4'b0001 || evt_overrun !== 4'h0)
            begin errors++; $display("FAIL ack_vs_edge: got pend=%b ovr=%b expected 0001 0000", evt_pending, evt_overrun); end
        evt_ack = 4'b0001;
        tick(1);
        evt_ack = 4'h0;
        checks++;
        if (evt_pending !== 4'h0)
            begin errors++; $display("FAIL ack_after: got pend=%b expected 0000", evt_pending); end
    endtask

    task automatic test_reset_midcount();
        int bad;
        async_in = 4'b0000;
        tick(6);
        checks++;
        if (filt_out !== 4'h0 || fall !== 4'b1001)
            begin errors++; $display("FAIL mid_prep: got filt=%b fall=%b expected 0000 1001", filt_out, fall); end
        tick(1);
        ack_all();
        async_in = 4'b1000;
        tick(5);
        n_rst = 1'b0;
        #1;
        checks++;
        if (filt_out !== 4'h0 || sync_out !== 4'h0 || rise !== 4'h0 || fall !== 4'h0)
            begin errors++; $display("FAIL mid_reset: got filt=%b sync=%b rise=%b fall=%b expected all 0000", filt_out, sync_out, rise, fall); end
        tick(1);
        n_rst = 1'b1;
        bad = 0;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            if (filt_out[3] || rise[3] || fall[3]) bad++;
        end
        checks++;
        if (bad != 0)
            begin errors++; $display("FAIL mid_restart: got %0d early cycles expected 0", bad); end
        tick(1);
        checks++;
        if (rise !== 4'b1000 || filt_out !== 4'b1000)
            begin errors++; $display("FAIL mid_rise: got rise=%b filt=%b expected 1000 1000", rise, filt_out); end
        tick(1);
        checks++;
        if (evt_pending !== 4'b1000 || rise !== 4'h0)
            begin errors++; $display("FAIL mid_pend: got pend=%b rise=%b expected 1000 0000", evt_pending, rise); end
    endtask

    task automatic test_stages3();
        int bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (s3 !== 4'b1010 || f3 !== 4'b1010 || r3 !== 4'h0 || fl3 !== 4'h0 ||
                p3 !== 4'h0 || o3 !== 4'h0) bad++;
        end
        checks++;
        if (bad != 0)
            begin errors++; $display("FAIL s3_quiet: got %0d bad cycles expected 0", bad); end
        a3 = 4'b1011;
        tick(2);
        checks++;
        if (s3 !== 4'b1010)
            begin errors++; $display("FAIL s3_sync_early: got %b expected 1010", s3); end
        tick(1);
        checks++;
        if (s3 !== 4'b1011)
            begin errors++; $display("FAIL s3_sync: got %b expected 1011", s3); end
        tick(3);
        checks++;
        if (f3 !== 4'b1010 || r3 !== 4'h0)
            begin errors++; $display("FAIL s3_filt_early: got filt=%b rise=%b expected 1010 0000", f3, r3); end
        tick(1);
        checks++;
        if (f3 !== 4'b1011 || r3 !== 4'b0001)
            begin errors++; $display("FAIL s3_rise: got filt=%b rise=%b expected 1011 0001", f3, r3); end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        n_rst    = 1'b0;
        async_in = 4'hF;
        evt_ack  = 4'h0;
        a3       = 4'b1010;
        ack3     = 4'h0;
        test_reset();
        test_overrun();
        test_ack_idle();
        test_glitch();
        test_boundary();
        test_ack_same_cycle();
        test_reset_midcount();
        test_stages3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
